uart_tx_param: RTL
==================

Name: uart_tx_param

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter. It supports configurable data width, parity mode and stop-bit count, and uses a valid/ready input handshake so upstream logic (FIFO, command sequencer) can stream bytes without dropping them. The block sits between the system-side byte source and the board TX pin.

Parameters:
CLKS_PER_BIT, 10417, clocks per serial bit (i_Clock freq / baud); legal range ≥2
DATA_BITS, 8, data bits per frame; legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2
BREAK_BITS, 13, break length in bit times (used only with UART_TX_BREAK_EN)

Ports:
i_Clock  in  1  system clock
i_Reset  in  1  reset, asynchronous, active-high
i_Tx_Valid  in  1  upstream has a word
i_Tx_Data  in  DATA_BITS  word to send, LSB first
o_Tx_Ready  out  1  block accepts a word this cycle
o_Tx_Serial  out  1  serial line, idle high
o_Tx_Active  out  1  frame or break in progress
o_Tx_Done  out  1  one-cycle pulse at frame end
i_Tx_Break  in  1  request a line break (present only with UART_TX_BREAK_EN)

Behaviour:
- One clock: i_Clock. Reset is asynchronous and active-high on i_Reset. All outputs are registered.
- Reset values: o_Tx_Serial = 1, o_Tx_Active = 0, o_Tx_Done = 0, o_Tx_Ready = 1. State is IDLE; bit counter and clock counter are 0.
- Handshake: a word is accepted on a clock edge where i_Tx_Valid && o_Tx_Ready. i_Tx_Data is captured at that edge. o_Tx_Ready drops on the next cycle. i_Tx_Data may change freely after acceptance.
- States and transitions:
  - IDLE → START, on accept.
  - START (line 0) → DATA.
  - DATA (bit[idx], idx 0..DATA_BITS-1) → PARITY if PARITY ≠ 0, else → STOP.
  - PARITY → STOP.
  - STOP (line 1, STOP_BITS bit times) → IDLE.
  - Illegal encodings → IDLE.
- Bit timing:
  - Every bit holds exactly CLKS_PER_BIT cycles.
  - The clock counter is $clog2(CLKS_PER_BIT) bits wide and wraps to 0 at CLKS_PER_BIT-1.
  - The falling start edge appears on the cycle after acceptance.
- Frame length: CLKS_PER_BIT × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles.
- Parity:
  - Even: parity bit = XOR of the data bits.
  - Odd: parity bit = inverted XOR of the data bits.
  - Computed from the captured word.
- End of frame: on the last cycle of the final stop bit, the next edge sets o_Tx_Done = 1 for exactly one cycle, o_Tx_Active = 0 and o_Tx_Ready = 1, all in the same cycle.
- Back-to-back frames: with i_Tx_Valid held high, the next word is accepted in that first IDLE cycle. Frames are separated by exactly one idle-high clock.
- o_Tx_Active is high from the cycle after acceptance through the last stop-bit cycle.
- Reset mid-frame: the line goes high immediately (asynchronously), the frame is abandoned and no Done pulse is produced.

Optional Feature:
Macro UART_TX_BREAK_EN.
- With the macro:
  - Adds i_Tx_Break and states BREAK and MARK.
  - In IDLE, i_Tx_Break has priority over i_Tx_Valid.
  - BREAK drives the line 0 for BREAK_BITS × CLKS_PER_BIT cycles. MARK then drives 1 for CLKS_PER_BIT cycles, then the block returns to IDLE.
  - During BREAK and MARK: o_Tx_Ready = 0 and o_Tx_Active = 1. No Done pulse is produced.
  - i_Tx_Break is sampled only in IDLE.
- Without the macro: the port, states and logic are absent, and behaviour is identical to the base description.

Decomposition:
- Package uart_pkg:
  - State encoding constants (IDLE, START, DATA, PARITY, STOP, BREAK, MARK).
  - Parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN.
  - Helper function for counter width.
- One sub-module, uart_bit_timer: a CLKS_PER_BIT counter with restart input and bit-end strobe output, reusable by the future parametrised receiver.

Test Plan:
- CLKS_PER_BIT=4, 8N1, send 8'hA5 → 40-cycle frame; line reads 0,1,0,1,0,0,1,0,1,1 (each 4 clocks); one Done pulse; Ready returns high with Done.
- 8E2, send 8'hA5 → parity bit 0, two stop bits, 48-cycle frame. 8O1, send 8'hA5 → parity bit 1, 44-cycle frame.
- DATA_BITS=5, send 5'h1F with PARITY=2 → parity bit 1, 32-cycle frame; upper bits absent.
- i_Tx_Valid held high with 8'h01 then 8'h02 → exactly one idle-high cycle between frames; no word lost or duplicated; two Done pulses.
- Assert i_Reset at cycle 10 of a frame → o_Tx_Serial = 1 the same cycle; Ready = 1 after release; no Done pulse; next send is a clean frame.
- UART_TX_BREAK_EN, BREAK_BITS=13, CLKS_PER_BIT=4: i_Tx_Break with i_Tx_Valid also high → 52 cycles low, 4 cycles high, then the word frame starts.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the parametrised UART blocks.
// Optional break generation in uart_tx_param is enabled by UART_TX_BREAK_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5,
    S_MARK   = 3'd6
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int ctr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Valid/ready word handshake between a byte source and the UART transmitter.
// Width follows the transmitter's DATA_BITS.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 Tx_Valid;
  logic [DATA_BITS-1:0] Tx_Data;
  logic                 Tx_Ready;

  modport master (
    output Tx_Valid,
    output Tx_Data,
    input  Tx_Ready
  );

  modport slave (
    input  Tx_Valid,
    input  Tx_Data,
    output Tx_Ready
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter: restart holds it at zero, strobe marks the last
// clock of each bit. Shared with the future parametrised receiver.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Restart,
  output logic o_Bit_End
);
  localparam int CW = ctr_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (i_Restart || cnt_q == LAST)
      cnt_d = '0;
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign o_Bit_End = !i_Restart && (cnt_q == LAST);
endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready input handshake.
// Define UART_TX_BREAK_EN to add i_Tx_Break and the BREAK/MARK sequence.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int BREAK_BITS   = 13
) (
  input  logic           i_Clock,
  input  logic           i_Reset,
  uart_tx_param_if.slave tx_if,
`ifdef UART_TX_BREAK_EN
  input  logic           i_Tx_Break,
`endif
  output logic           o_Tx_Serial,
  output logic           o_Tx_Active,
  output logic           o_Tx_Done
);
  localparam int MAXC = (DATA_BITS > BREAK_BITS) ? DATA_BITS : BREAK_BITS;
  localparam int IW = ctr_width(MAXC);
  localparam bit HAS_PAR = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);
  localparam bit ODD = (PARITY == PAR_ODD);

  state_e               state_q;
  logic [DATA_BITS-1:0] sh_q;
  logic                 par_q;
  logic [IW-1:0]        idx_q;
  logic                 serial_q;
  logic                 active_q;
  logic                 done_q;
  logic                 ready_q;
  logic                 bit_end;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Restart(state_q == S_IDLE),
    .o_Bit_End(bit_end)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= S_IDLE;
      sh_q     <= '0;
      par_q    <= 1'b0;
      idx_q    <= '0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (i_Tx_Break) begin
            state_q  <= S_BREAK;
            idx_q    <= '0;
            serial_q <= 1'b0;
            active_q <= 1'b1;
            ready_q  <= 1'b0;
          end else
`endif
          if (tx_if.Tx_Valid && ready_q) begin
            state_q  <= S_START;
            sh_q     <= tx_if.Tx_Data;
            par_q    <= (^tx_if.Tx_Data) ^ ODD;
            serial_q <= 1'b0;
            active_q <= 1'b1;
            ready_q  <= 1'b0;
          end
        end
        S_START: if (bit_end) begin
          state_q  <= S_DATA;
          idx_q    <= '0;
          serial_q <= sh_q[0];
        end
        S_DATA: if (bit_end) begin
          if (idx_q == IW'(DATA_BITS - 1)) begin
            idx_q <= '0;
            if (HAS_PAR) begin
              state_q  <= S_PARITY;
              serial_q <= par_q;
            end else begin
              state_q  <= S_STOP;
              serial_q <= 1'b1;
            end
          end else begin
            idx_q    <= idx_q + IW'(1);
            sh_q     <= sh_q >> 1;
            serial_q <= sh_q[1];
          end
        end
        S_PARITY: if (bit_end) begin
          state_q  <= S_STOP;
          serial_q <= 1'b1;
        end
        S_STOP: if (bit_end) begin
          if (idx_q == IW'(STOP_BITS - 1)) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            active_q <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b1;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
`ifdef UART_TX_BREAK_EN
        S_BREAK: if (bit_end) begin
          if (idx_q == IW'(BREAK_BITS - 1)) begin
            state_q  <= S_MARK;
            idx_q    <= '0;
            serial_q <= 1'b1;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        S_MARK: if (bit_end) begin
          state_q  <= S_IDLE;
          active_q <= 1'b0;
          ready_q  <= 1'b1;
        end
`endif
        default: begin
          state_q  <= S_IDLE;
          idx_q    <= '0;
          serial_q <= 1'b1;
          active_q <= 1'b0;
          ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign tx_if.Tx_Ready = ready_q;
  assign o_Tx_Serial    = serial_q;
  assign o_Tx_Active    = active_q;
  assign o_Tx_Done      = done_q;
endmodule
